// File: rtl/pc_fetch.sv
// Program-counter / fetch sequencer: start/halt FSM, stall hold, absolute branch
// targets from the ROM branch table, retired-fetch counter. Optional PC_LINK_EN adds a one-entry call/return link.
module pc_fetch #(
    parameter int D          = 12,
    parameter int B          = 8,
    parameter int START_ADDR = 0,
    parameter int CNT_W      = 16,
    localparam int BW        = (B > 1) ? $clog2(B) : 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic                  stall,
    input  logic                  halt_req,
    input  logic                  branch_taken,
    input  logic [BW-1:0]         branch_sel,
    input  logic                  call_en,
    input  logic                  ret_en,
    input  logic [B-1:0][D-1:0]   branch_table,
    output logic [D-1:0]          prog_ctr,
    output logic                  fetch_valid,
    output logic                  done,
    output logic                  overflow,
    output logic [CNT_W-1:0]      instr_count,
    output logic [1:0]            state_dbg
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [D-1:0]      pc_q, pc_d;
    logic              fv_q, fv_d;
    logic              done_q, done_d;
    logic              ovf_q, ovf_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [D-1:0]      target;
    logic              take_seq;

`ifdef PC_LINK_EN
    logic [D-1:0]      link_q, link_d;
    logic              lv_q, lv_d;
`else
    logic              unused_ret;
    assign unused_ret = ret_en;
`endif

    // Out-of-range selects resolve to address 0 rather than X.
    always_comb begin
        target = '0;
        for (int i = 0; i < B; i++) begin
            if (branch_sel == BW'(i)) target = branch_table[i];
        end
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        fv_d     = fv_q;
        done_d   = done_q;
        ovf_d    = ovf_q;
        cnt_d    = cnt_q;
        take_seq = 1'b0;
`ifdef PC_LINK_EN
        link_d   = link_q;
        lv_d     = lv_q;
`endif
        case (state_q)
            IDLE, HALT: begin
                if (start) begin
                    state_d = RUN;
                    pc_d    = D'(START_ADDR);
                    fv_d    = 1'b1;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                    done_d  = 1'b0;
`ifdef PC_LINK_EN
                    lv_d    = 1'b0;
`endif
                end
            end
            RUN: begin
                // A stalled cycle holds everything; the decoder re-presents its requests.
                if (!stall) begin
                    if (halt_req) begin
                        state_d = HALT;
                        fv_d    = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
`ifdef PC_LINK_EN
                        if (ret_en) begin
                            if (lv_q) begin
                                pc_d = link_q;
                                lv_d = 1'b0;
                            end else begin
                                take_seq = 1'b1;
                            end
                        end else if (call_en) begin
                            link_d = pc_q + 1'b1;
                            lv_d   = 1'b1;
                            pc_d   = target;
                        end else if (branch_taken) begin
                            pc_d = target;
                        end else begin
                            take_seq = 1'b1;
                        end
`else
                        if (call_en || branch_taken) pc_d = target;
                        else                         take_seq = 1'b1;
`endif
                        // Running off the top of the ROM halts with the PC parked on the last word.
                        if (take_seq) begin
                            if (pc_q == '1) begin
                                state_d = HALT;
                                ovf_d   = 1'b1;
                                fv_d    = 1'b0;
                                done_d  = 1'b1;
                            end else begin
                                pc_d = pc_q + 1'b1;
                            end
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            pc_q    <= '0;
            fv_q    <= 1'b0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
`ifdef PC_LINK_EN
            link_q  <= '0;
            lv_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            fv_q    <= fv_d;
            done_q  <= done_d;
            ovf_q   <= ovf_d;
            cnt_q   <= cnt_d;
`ifdef PC_LINK_EN
            link_q  <= link_d;
            lv_q    <= lv_d;
`endif
        end
    end

    assign prog_ctr    = pc_q;
    assign fetch_valid = fv_q;
    assign done        = done_q;
    assign overflow    = ovf_q;
    assign instr_count = cnt_q;
    assign state_dbg   = state_q;

endmodule
